// File: rtl/mux_src_arbiter.sv
// ---------------------------------------------------------------------------
// mux_src_arbiter
//
// Round-robin arbiter choosing which of five sources drives a shared mux.
// Each requester holds its req bit high while it wants the mux.
//
// A new owner is found by searching upward from the source after the last
// owner, wrapping around. The current owner keeps the grant while its req
// stays high. When it drops req, the grant passes straight to the next
// winner. If no other source is requesting, the block goes idle.
//
// Optional feature, enabled by defining the macro ARB_HOLD_LIMIT_EN:
//   Once the owner has held the grant for MAX_HOLD cycles and another source
//   is waiting, the grant is forced over to the next round-robin winner.
//   Without the macro, an owner is never pre-empted.
//
// Parameters
//   MAX_HOLD  : consecutive grant cycles before forced rotation (1..255)
// Ports
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   req[4:0]  : level request per source
//   gnt[4:0]  : one-hot grant, zero when idle (registered)
//   sel[2:0]  : binary index of the owner; holds its value while idle
//   busy      : high whenever any gnt bit is high
//   hold_cnt  : cycles the current owner has held the grant, saturating at
//               255; zero while idle
// ---------------------------------------------------------------------------
module mux_src_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] req,
   output logic [4:0] gnt,
   output logic [2:0] sel,
   output logic       busy,
   output logic [7:0] hold_cnt
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_reg, state_next;
   logic [4:0] gnt_reg, gnt_next;
   logic [2:0] sel_reg, sel_next;
   logic       busy_reg, busy_next;
   logic [7:0] hold_cnt_reg, hold_cnt_next;
   logic [2:0] last_owner_reg, last_owner_next;

   logic [4:0] others;
   logic [3:0] pick_all, pick_others;
   logic       owner_req;
   logic       hold_limit_hit;

   // Reject an out-of-range hold limit when the design is elaborated.
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("mux_src_arbiter: MAX_HOLD must be within 1..255");
   end

   // Round-robin search. It starts at (last + 1) mod 5 and wraps around.
   // The result is {found, index}.
   function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] last);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0000;
      for (int k = 1; k <= 5; k++) begin
         idx = 3'((32'(last) + 32'(k)) % 32'd5);
         if (!res[3] && r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   // gnt_reg is zero when idle, so 'others' equals req in that state.
   // While granting, 'others' removes the owner from the search.
   assign others      = req & ~gnt_reg;
   assign owner_req   = |(req & gnt_reg);
   assign pick_all    = rr_pick(req, last_owner_reg);
   assign pick_others = rr_pick(others, last_owner_reg);

`ifdef ARB_HOLD_LIMIT_EN
   assign hold_limit_hit = (hold_cnt_reg == 8'(MAX_HOLD)) && (|others);
`else
   assign hold_limit_hit = 1'b0;
`endif

   always_comb begin
      state_next      = state_reg;
      gnt_next        = gnt_reg;
      sel_next        = sel_reg;
      hold_cnt_next   = hold_cnt_reg;
      last_owner_next = last_owner_reg;

      case (state_reg)
         IDLE: begin
            gnt_next      = 5'b00000;
            hold_cnt_next = 8'd0;
            if (pick_all[3]) begin
               state_next      = GRANT;
               gnt_next        = 5'(5'b00001 << pick_all[2:0]);
               sel_next        = pick_all[2:0];
               hold_cnt_next   = 8'd1;
               last_owner_next = pick_all[2:0];
            end
         end
         GRANT: begin
            if (owner_req && !hold_limit_hit) begin
               if (hold_cnt_reg != 8'd255) begin
                  hold_cnt_next = hold_cnt_reg + 8'd1;
               end
            end else if (pick_others[3]) begin
               // Either a handover after the owner released, or a forced
               // rotation. In both cases there is no idle cycle between owners.
               gnt_next        = 5'(5'b00001 << pick_others[2:0]);
               sel_next        = pick_others[2:0];
               hold_cnt_next   = 8'd1;
               last_owner_next = pick_others[2:0];
            end else begin
               state_next    = IDLE;
               gnt_next      = 5'b00000;
               hold_cnt_next = 8'd0;
            end
         end
         default: begin
            state_next    = IDLE;
            gnt_next      = 5'b00000;
            hold_cnt_next = 8'd0;
         end
      endcase

      busy_next = |gnt_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         gnt_reg        <= 5'b00000;
         sel_reg        <= 3'b000;
         busy_reg       <= 1'b0;
         hold_cnt_reg   <= 8'd0;
         // Last owner starts at 4, so source 0 is searched first after reset.
         last_owner_reg <= 3'd4;
      end else begin
         state_reg      <= state_next;
         gnt_reg        <= gnt_next;
         sel_reg        <= sel_next;
         busy_reg       <= busy_next;
         hold_cnt_reg   <= hold_cnt_next;
         last_owner_reg <= last_owner_next;
      end
   end

   assign gnt      = gnt_reg;
   assign sel      = sel_reg;
   assign busy     = busy_reg;
   assign hold_cnt = hold_cnt_reg;

endmodule

// File: tb/tb_mux_src_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_src_arbiter
//
// Self-checking bench for mux_src_arbiter with MAX_HOLD = 3.
// A behavioural model (owner index, last owner, hold count) predicts the
// outputs from the arbitration rules. One compare process checks the DUT
// against the model on every falling edge. Directed sequences add literal
// expectations that pin down the model. Randomized requests and occasional
// resets follow the directed part.
// Build with or without ARB_HOLD_LIMIT_EN; the bench follows the macro.
// ---------------------------------------------------------------------------
module tb_mux_src_arbiter;

   localparam int MAX_HOLD_TB = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] req;
   logic [4:0] gnt;
   logic [2:0] sel;
   logic       busy;
   logic [7:0] hold_cnt;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Behavioural model state. exp_owner is -1 when idle.
   int exp_owner = -1;
   int exp_last  = 4;
   int exp_hold  = 0;
   int exp_sel   = 0;

   mux_src_arbiter #(.MAX_HOLD(MAX_HOLD_TB)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .gnt      (gnt),
      .sel      (sel),
      .busy     (busy),
      .hold_cnt (hold_cnt)
   );

   always #5 clk = ~clk;

   // Returns the first set bit at or after (last + 1), wrapping; -1 if none.
   function automatic int rr(input logic [4:0] q, input int last);
      for (int k = 1; k <= 5; k++) begin
         if (q[(last + k) % 5]) return (last + k) % 5;
      end
      return -1;
   endfunction

   task automatic take(input int w);
      exp_owner = w;
      exp_last  = w;
      exp_sel   = w;
      exp_hold  = 1;
   endtask

   task automatic model_update(input logic r, input logic [4:0] q);
      logic [4:0] oth;
      bit         forced;
      int         w;
      if (r) begin
         exp_owner = -1; exp_last = 4; exp_hold = 0; exp_sel = 0;
      end else if (exp_owner < 0) begin
         w = rr(q, exp_last);
         if (w >= 0) take(w);
      end else begin
         oth = q;
         oth[exp_owner] = 1'b0;
         forced = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
         if (exp_hold == MAX_HOLD_TB && oth != 5'b0) forced = 1'b1;
`endif
         if (q[exp_owner] && !forced) begin
            exp_hold = (exp_hold < 255) ? exp_hold + 1 : 255;
         end else begin
            w = rr(oth, exp_owner);
            if (w >= 0) take(w);
            else begin
               exp_owner = -1; exp_hold = 0;
            end
         end
      end
   endtask

   // Single comparison against the model, once per cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [4:0] eg;
         eg = (exp_owner < 0) ? 5'b0 : 5'(5'b00001 << exp_owner);
         tests++;
         if (gnt !== eg || sel !== 3'(exp_sel) || busy !== (exp_owner >= 0) ||
             hold_cnt !== 8'(exp_hold)) begin
            fails++;
            $display("FAIL model_cmp t=%0t req=%b: gnt=%b sel=%0d busy=%b hold=%0d, required gnt=%b sel=%0d busy=%0b hold=%0d",
                     $time, req, gnt, sel, busy, hold_cnt, eg, exp_sel, exp_owner >= 0, exp_hold);
         end
      end
   end

   // Applies inputs for one edge, steps the model, and returns at negedge+1.
   task automatic tick(input logic r, input logic [4:0] q);
      reset = r;
      req   = q;
      @(posedge clk);
      model_update(r, q);
      chk_en = 1'b1;
      @(negedge clk);
      #1;
      $display("[TB] reset=%b req=%b -> gnt=%b sel=%0d busy=%b hold_cnt=%0d",
               r, q, gnt, sel, busy, hold_cnt);
   endtask

   task automatic lit(input string name, input logic [4:0] g, input logic [2:0] s,
                      input logic b, input logic [7:0] h);
      tests++;
      if (gnt !== g || sel !== s || busy !== b || hold_cnt !== h) begin
         fails++;
         $display("FAIL %s: got gnt=%b sel=%0d busy=%b hold=%0d, required gnt=%b sel=%0d busy=%b hold=%0d",
                  name, gnt, sel, busy, hold_cnt, g, s, b, h);
      end
   endtask

   initial begin
      logic [4:0] q;
      reset = 1'b1;
      req   = 5'b0;

      // Reset for 2 cycles, then two sources request.
      tick(1'b1, 5'b10100);
      tick(1'b1, 5'b10100);
      lit("reset_state", 5'b00000, 3'd0, 1'b0, 8'd0);
      tick(1'b0, 5'b10100);
      lit("first_grant", 5'b00100, 3'd2, 1'b1, 8'd1);
      tick(1'b0, 5'b10000);
      lit("handover_no_bubble", 5'b10000, 3'd4, 1'b1, 8'd1);
      tick(1'b0, 5'b00000);
      lit("release_to_idle_sel_held", 5'b00000, 3'd4, 1'b0, 8'd0);

      // Round-robin order: each owner releases after one cycle.
      tick(1'b1, 5'b11111);
      tick(1'b0, 5'b11111);
      lit("rr_order_0", 5'b00001, 3'd0, 1'b1, 8'd1);
      tick(1'b0, 5'b11110);
      lit("rr_order_1", 5'b00010, 3'd1, 1'b1, 8'd1);
      tick(1'b0, 5'b11101);
      lit("rr_order_2", 5'b00100, 3'd2, 1'b1, 8'd1);
      tick(1'b0, 5'b11011);
      lit("rr_order_3", 5'b01000, 3'd3, 1'b1, 8'd1);
      tick(1'b0, 5'b10111);
      lit("rr_order_4", 5'b10000, 3'd4, 1'b1, 8'd1);
      tick(1'b0, 5'b01111);
      lit("rr_order_0_again", 5'b00001, 3'd0, 1'b1, 8'd1);

      // Hold limit: owner 1 holds, then source 3 starts requesting.
      tick(1'b1, 5'b00000);
      tick(1'b0, 5'b00010);
      tick(1'b0, 5'b00010);
      lit("hold_count_2", 5'b00010, 3'd1, 1'b1, 8'd2);
      tick(1'b0, 5'b01010);
      lit("hold_count_3", 5'b00010, 3'd1, 1'b1, 8'd3);
      tick(1'b0, 5'b01010);
`ifdef ARB_HOLD_LIMIT_EN
      lit("forced_rotation", 5'b01000, 3'd3, 1'b1, 8'd1);
`else
      lit("no_forced_rotation", 5'b00010, 3'd1, 1'b1, 8'd4);
`endif

      // Lone requester saturates hold_cnt at 255.
      tick(1'b1, 5'b00000);
      for (int i = 0; i < 300; i++) tick(1'b0, 5'b00010);
      lit("hold_saturate", 5'b00010, 3'd1, 1'b1, 8'd255);

      // Reset in the middle of a grant, then source 0 wins first.
      tick(1'b1, 5'b00000);
      tick(1'b0, 5'b01000);
      lit("grant_3", 5'b01000, 3'd3, 1'b1, 8'd1);
      tick(1'b1, 5'b11111);
      lit("reset_mid_grant", 5'b00000, 3'd0, 1'b0, 8'd0);
      tick(1'b0, 5'b11111);
      lit("post_reset_req0_first", 5'b00001, 3'd0, 1'b1, 8'd1);

      // Randomized requests: each bit toggles now and then, with occasional resets.
      q = 5'b0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 5; b++) begin
            if ($urandom_range(5) == 0) q[b] = ~q[b];
         end
         tick($urandom_range(99) == 0, q);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
